draw_layer_arbiter_mux: RTL and testbench
=========================================

Name: draw_layer_arbiter_mux

Overview:
- Parametrised N-channel draw-request arbiter for the VGA object path.
- Each cycle it selects one requesting object unit by layer priority.
- Registers that unit's X/Y offsets and collision flag for the shared bitmap/colour stage.
- Also produces per-frame overlap flags, which game logic reads at start of frame.

Parameters:
- NUM_CH, 8, number of object channels (2..16).
- COORD_W, 11, width of offsetX/offsetY per channel.
- PRI_W, 4, width of each channel's priority value; must satisfy 2^PRI_W >= NUM_CH.
- PRI_MODE, 1, 0 = fixed priority (lowest index wins, cfg ignored); 1 = programmable priority registers.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- offsetX  in  NUM_CH*COORD_W  packed; channel i in bits [i*COORD_W +: COORD_W].
- offsetY  in  NUM_CH*COORD_W  packed, same layout.
- drawRequest  in  NUM_CH  per-channel draw request.
- collisionIn  in  NUM_CH  per-channel collision flag.
- cfg_wr  in  1  write strobe for priority register.
- cfg_idx  in  4  channel index to write.
- cfg_pri  in  PRI_W  priority value; larger wins.
- offset_x  out  COORD_W  winner X offset.
- offset_y  out  COORD_W  winner Y offset.
- drawRequestOut  out  1  any channel requesting.
- collision  out  1  winner's collision flag.
- winner_idx  out  4  index of selected channel.
- overlap_frame  out  NUM_CH  previous frame's overlap flags.

Behaviour:
- Reset (sync, active-high, dominates all other inputs):
  - all outputs 0.
  - overlap accumulator 0.
  - pri[i] = NUM_CH-1-i, which equals the fixed ordering.
- Latency: 1 clock, inputs sampled at edge k appear on outputs after edge k. All outputs registered.
- drawRequestOut <= OR of drawRequest.
- Winner selection:
  - Winner = requesting channel with the largest pri[i].
  - Ties go to the lowest index.
  - PRI_MODE=0 uses index order only.
- With a winner: offset_x/offset_y/collision <= winner's values; winner_idx <= winner index.
- With no request: offset_x, offset_y and collision <= 0; winner_idx <= 0.
- Config write:
  - cfg_wr with cfg_idx < NUM_CH writes pri[cfg_idx].
  - cfg_idx >= NUM_CH is ignored.
  - The new value affects arbitration from the following cycle only; the same-cycle decision uses the old value.
  - PRI_MODE=0: cfg_wr ignored and pri is not stored.
- Overlap accumulator:
  - Each cycle, bit i is set if drawRequest[i]=1 and at least one other drawRequest bit is 1 in the same cycle.
  - Bits are sticky until frame start.
- Frame start (startOfFrame=1):
  - overlap_frame <= accumulator OR same-cycle overlap.
  - Accumulator <= 0; the current pixel belongs to the ending frame.
  - overlap_frame holds until the next startOfFrame.
- Arbitration is unaffected by startOfFrame or cfg_wr except as stated above.
- Reset mid-frame clears the accumulator, overlap_frame and pri; the next frame starts clean.
- No combinational path from inputs to outputs.

Test Plan:
- Reset:
  - Stimulus: reset=1 for 2 cycles with drawRequest=8'hFF.
  - Response: all outputs 0 during reset. The cycle after release: drawRequestOut=1 and winner_idx=0.
- Fixed-order priority:
  - Stimulus: drawRequest=8'b0010_0100, offsetX ch2=100, ch5=200, collisionIn[2]=1.
  - Response: one cycle later offset_x=100, collision=1, winner_idx=2.
- Programmable priority:
  - Stimulus: cfg_wr idx=5 pri=15 in cycle k, same request as the previous scenario held.
  - Response: output after edge k shows winner 2. Output after edge k+1 shows winner 5, offset_x=200.
- Ties and invalid index:
  - Stimulus: write pri[3]=pri[6]=9, request ch3+ch6. Then cfg_idx=12 write.
  - Response: winner 3. Invalid write leaves the priority table unchanged.
- Overlap flags:
  - Stimulus: frame 1 has ch1+ch4 together for 1 cycle and ch7 alone. Then startOfFrame.
  - Response: overlap_frame=8'b0001_0010. It stays unchanged through frame 2 and clears to 0 at the following startOfFrame if no overlaps occur.
- Frame-start coincidence:
  - Stimulus: startOfFrame in the same cycle as a ch0+ch2 request.
  - Response: overlap_frame includes bits 0 and 2; the accumulator is empty afterwards.

Source files
------------

// File: rtl/draw_layer_arbiter_mux_if.sv
// Bus bundle for the draw-layer arbiter: per-channel object inputs, priority
// config port and the registered winner / overlap outputs.
interface draw_layer_arbiter_mux_if #(
    parameter int NUM_CH  = 8,
    parameter int COORD_W = 11,
    parameter int PRI_W   = 4
);
    logic                       startOfFrame;
    logic [NUM_CH*COORD_W-1:0]  offsetX;
    logic [NUM_CH*COORD_W-1:0]  offsetY;
    logic [NUM_CH-1:0]          drawRequest;
    logic [NUM_CH-1:0]          collisionIn;
    logic                       cfg_wr;
    logic [3:0]                 cfg_idx;
    logic [PRI_W-1:0]           cfg_pri;

    logic [COORD_W-1:0]         offset_x;
    logic [COORD_W-1:0]         offset_y;
    logic                       drawRequestOut;
    logic                       collision;
    logic [3:0]                 winner_idx;
    logic [NUM_CH-1:0]          overlap_frame;

    modport master (
        output startOfFrame, offsetX, offsetY, drawRequest, collisionIn,
               cfg_wr, cfg_idx, cfg_pri,
        input  offset_x, offset_y, drawRequestOut, collision, winner_idx,
               overlap_frame
    );

    modport slave (
        input  startOfFrame, offsetX, offsetY, drawRequest, collisionIn,
               cfg_wr, cfg_idx, cfg_pri,
        output offset_x, offset_y, drawRequestOut, collision, winner_idx,
               overlap_frame
    );
endinterface

// File: rtl/draw_layer_arbiter_mux.sv
// N-channel draw-request arbiter: picks the highest-priority requesting object
// each cycle, registers its offsets/collision, and tracks per-frame overlaps.
module draw_layer_arbiter_mux #(
    parameter int NUM_CH   = 8,
    parameter int COORD_W  = 11,
    parameter int PRI_W    = 4,
    parameter int PRI_MODE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    draw_layer_arbiter_mux_if.slave bus
);

    logic [PRI_W-1:0]   pri_eff [NUM_CH];

    logic               any_req;
    logic [3:0]         win_idx;
    logic [COORD_W-1:0] win_x;
    logic [COORD_W-1:0] win_y;
    logic               win_col;
    logic [NUM_CH-1:0]  same_ovl;

    logic [COORD_W-1:0] offset_x_p1;
    logic [COORD_W-1:0] offset_y_p1;
    logic               draw_out_p1;
    logic               collision_p1;
    logic [3:0]         winner_idx_p1;
    logic [NUM_CH-1:0]  overlap_acc_p1;
    logic [NUM_CH-1:0]  overlap_frame_p1;

    generate
        if (PRI_MODE == 1) begin : g_prog_pri
            // A write lands after the edge, so the same-cycle decision still
            // sees the old table.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < NUM_CH; i++)
                        pri_eff[i] <= PRI_W'(NUM_CH - 1 - i);
                end else if (bus.cfg_wr) begin
                    for (int i = 0; i < NUM_CH; i++)
                        if (bus.cfg_idx == 4'(i))
                            pri_eff[i] <= bus.cfg_pri;
                end
            end
        end else begin : g_fixed_pri
            for (genvar g = 0; g < NUM_CH; g++) begin : g_const
                assign pri_eff[g] = PRI_W'(NUM_CH - 1 - g);
            end
        end
    endgenerate

    // Strict greater-than while scanning upward keeps ties on the lowest index.
    always_comb begin
        win_idx = 4'd0;
        win_x   = '0;
        win_y   = '0;
        win_col = 1'b0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.drawRequest[i] && (!any_req || pri_eff[i] > pri_eff[win_idx])) begin
                any_req = 1'b1;
                win_idx = 4'(i);
                win_x   = bus.offsetX[i*COORD_W +: COORD_W];
                win_y   = bus.offsetY[i*COORD_W +: COORD_W];
                win_col = bus.collisionIn[i];
            end
        end
    end

    // Every requester overlaps once two or more bits are set.
    always_comb begin
        same_ovl = '0;
        if (|(bus.drawRequest & (bus.drawRequest - NUM_CH'(1))))
            same_ovl = bus.drawRequest;
    end

    // ---- stage p1: registered outputs and overlap bookkeeping ----
    always_ff @(posedge clk) begin
        if (reset) begin
            offset_x_p1      <= '0;
            offset_y_p1      <= '0;
            draw_out_p1      <= 1'b0;
            collision_p1     <= 1'b0;
            winner_idx_p1    <= 4'd0;
            overlap_acc_p1   <= '0;
            overlap_frame_p1 <= '0;
        end else begin
            draw_out_p1   <= any_req;
            offset_x_p1   <= win_x;
            offset_y_p1   <= win_y;
            collision_p1  <= win_col;
            winner_idx_p1 <= win_idx;
            if (bus.startOfFrame) begin
                overlap_frame_p1 <= overlap_acc_p1 | same_ovl;
                overlap_acc_p1   <= '0;
            end else begin
                overlap_acc_p1   <= overlap_acc_p1 | same_ovl;
            end
        end
    end

    assign bus.offset_x       = offset_x_p1;
    assign bus.offset_y       = offset_y_p1;
    assign bus.drawRequestOut = draw_out_p1;
    assign bus.collision      = collision_p1;
    assign bus.winner_idx     = winner_idx_p1;
    assign bus.overlap_frame  = overlap_frame_p1;

endmodule

// File: tb/tb_draw_layer_arbiter_mux.sv
// Scoreboard bench for draw_layer_arbiter_mux: directed scenarios followed by
// random traffic, all checked against a priority-score reference model.
module tb_draw_layer_arbiter_mux;
    localparam int NUM_CH  = 8;
    localparam int COORD_W = 11;
    localparam int PRI_W   = 4;

    typedef struct {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               dro;
        logic               col;
        logic [3:0]         widx;
        logic [NUM_CH-1:0]  ovl;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    draw_layer_arbiter_mux_if #(.NUM_CH(NUM_CH), .COORD_W(COORD_W), .PRI_W(PRI_W)) bus ();

    draw_layer_arbiter_mux #(
        .NUM_CH(NUM_CH), .COORD_W(COORD_W), .PRI_W(PRI_W), .PRI_MODE(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // stimulus values for the next cycle
    logic               s_rst, s_sof, s_cwr;
    logic [NUM_CH-1:0]  s_req, s_col;
    logic [3:0]         s_cidx;
    logic [PRI_W-1:0]   s_cpri;
    logic [COORD_W-1:0] s_x [NUM_CH];
    logic [COORD_W-1:0] s_y [NUM_CH];

    // reference model state
    int                 m_pri [NUM_CH];
    logic [NUM_CH-1:0]  m_acc, m_ovl;

    function automatic exp_t model_cycle();
        exp_t e;
        int   best_score, best;
        logic [NUM_CH-1:0] same;
        e = '{x: '0, y: '0, dro: 1'b0, col: 1'b0, widx: 4'd0, ovl: '0};
        if (s_rst) begin
            m_acc = '0;
            m_ovl = '0;
            for (int i = 0; i < NUM_CH; i++) m_pri[i] = NUM_CH - 1 - i;
            return e;
        end
        // Score: priority first, then lower index as the tie breaker.
        best_score = -1;
        best = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            int score;
            score = m_pri[i] * NUM_CH + (NUM_CH - 1 - i);
            if (s_req[i] && score > best_score) begin
                best_score = score;
                best = i;
            end
        end
        if (s_req != 0) begin
            e.dro  = 1'b1;
            e.x    = s_x[best];
            e.y    = s_y[best];
            e.col  = s_col[best];
            e.widx = 4'(best);
        end
        same = ($countones(s_req) >= 2) ? s_req : '0;
        if (s_sof) begin
            m_ovl = m_acc | same;
            m_acc = '0;
        end else begin
            m_acc = m_acc | same;
        end
        e.ovl = m_ovl;
        if (s_cwr && s_cidx < NUM_CH) m_pri[s_cidx] = int'(s_cpri);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
        reset            = s_rst;
        bus.startOfFrame = s_sof;
        bus.drawRequest  = s_req;
        bus.collisionIn  = s_col;
        bus.cfg_wr       = s_cwr;
        bus.cfg_idx      = s_cidx;
        bus.cfg_pri      = s_cpri;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.offsetX[i*COORD_W +: COORD_W] = s_x[i];
            bus.offsetY[i*COORD_W +: COORD_W] = s_y[i];
        end
        sb.push_back(model_cycle());
    endtask

    task automatic idle_inputs();
        s_rst = 1'b0; s_sof = 1'b0; s_cwr = 1'b0;
        s_req = '0; s_col = '0; s_cidx = 4'd0; s_cpri = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s_x[i] = COORD_W'(10 * i + 1);
            s_y[i] = COORD_W'(20 * i + 3);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: every cycle with a pending expectation, compare outputs
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("offset_x",       32'(bus.offset_x),       32'(e.x));
                chk("offset_y",       32'(bus.offset_y),       32'(e.y));
                chk("drawRequestOut", 32'(bus.drawRequestOut), 32'(e.dro));
                chk("collision",      32'(bus.collision),      32'(e.col));
                chk("winner_idx",     32'(bus.winner_idx),     32'(e.widx));
                chk("overlap_frame",  32'(bus.overlap_frame),  32'(e.ovl));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.startOfFrame = 1'b0; bus.drawRequest = '0; bus.collisionIn = '0;
        bus.cfg_wr = 1'b0; bus.cfg_idx = 4'd0; bus.cfg_pri = '0;
        bus.offsetX = '0; bus.offsetY = '0;
        for (int i = 0; i < NUM_CH; i++) m_pri[i] = NUM_CH - 1 - i;
        m_acc = '0; m_ovl = '0;
        idle_inputs();

        // reset held with all channels requesting, then released
        s_rst = 1'b1; s_req = 8'hFF;
        repeat (2) step();
        s_rst = 1'b0;
        step();

        // fixed ordering: ch2 beats ch5
        idle_inputs();
        s_req = 8'b0010_0100; s_x[2] = 11'd100; s_x[5] = 11'd200; s_col[2] = 1'b1;
        step();
        // raise ch5 to 15: same-cycle decision still ch2, next cycle ch5
        s_cwr = 1'b1; s_cidx = 4'd5; s_cpri = 4'd15;
        step();
        s_cwr = 1'b0;
        repeat (2) step();

        // ties between ch3 and ch6, then an out-of-range write
        s_cwr = 1'b1; s_cidx = 4'd3; s_cpri = 4'd9; step();
        s_cidx = 4'd6; step();
        s_cwr = 1'b0; s_req = 8'b0100_1000; step();
        s_cwr = 1'b1; s_cidx = 4'd12; s_cpri = 4'd15; step();
        s_cwr = 1'b0; repeat (2) step();

        // overlap frames: ch1+ch4 once, ch7 alone, then two frame starts
        idle_inputs();
        s_sof = 1'b1; step(); s_sof = 1'b0;
        s_req = 8'b0001_0010; step();
        s_req = 8'b1000_0000; step();
        s_req = '0; step();
        s_sof = 1'b1; step(); s_sof = 1'b0;
        s_req = 8'b0000_0001; repeat (3) step();
        s_req = '0;
        s_sof = 1'b1; step(); s_sof = 1'b0;
        step();

        // frame start coinciding with a ch0+ch2 overlap
        s_sof = 1'b1; s_req = 8'b0000_0101; step();
        s_sof = 1'b0; s_req = '0; repeat (2) step();
        s_sof = 1'b1; step(); s_sof = 1'b0;
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s_rst  = ($urandom_range(0, 499) == 0);
            s_sof  = ($urandom_range(0, 39) == 0);
            s_cwr  = ($urandom_range(0, 9) == 0);
            s_cidx = 4'($urandom_range(0, 15));
            s_cpri = PRI_W'($urandom);
            s_req  = ($urandom_range(0, 1) == 0) ? NUM_CH'($urandom & $urandom) : NUM_CH'($urandom);
            s_col  = NUM_CH'($urandom);
            for (int i = 0; i < NUM_CH; i++) begin
                s_x[i] = COORD_W'($urandom);
                s_y[i] = COORD_W'($urandom);
            end
            step();
        end

        idle_inputs();
        step();
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
